wb_fifo_slave: RTL and testbench

- Wishbone classic slave that bridges the J1 CPU bus to two byte-stream-style FIFO channels.
- TX channel: CPU writes words, a downstream consumer drains them over a valid/ready stream.
- RX channel: an upstream producer fills it over a valid/ready stream, and the CPU reads words out.
- Sits in the CPU-side interconnect as a decoded slave in the peripheral window; the interconnect gates stb_i.

---
 rtl/wb_fifo_slave.sv | 180 ++++++++++++++++++
 tb/tb_wb_fifo_slave.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fifo_slave.sv
// Wishbone classic slave that bridges the CPU bus to a TX and an RX FIFO channel.
// The CPU pushes words into TX and a consumer drains them; a producer fills RX and the CPU pops it.
module wb_fifo_slave #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [15:0]   adr_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o,
  input  logic          we_i,
  input  logic          cyc_i,
  input  logic          stb_i,
  output logic          ack_o,
  output logic [DW-1:0] tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  input  logic [DW-1:0] rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic          irq_o
);

  // Handshakes: the CPU side is Wishbone classic and takes one wait state.
  // A request edge is any edge where cyc_i & stb_i are high and ack_o is low.
  // ack_o is high for exactly the cycle after that edge.
  // Each stream transfers a word on an edge where its valid and ready are both high.
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  logic          ack_q;
  logic [DW-1:0] dat_q;
  logic          tx_ovf;
  logic          rx_unf;

  logic [DW-1:0] tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr;
  logic [AW-1:0] tx_rd_ptr;
  logic [AW:0]   tx_count;

  logic [DW-1:0] rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr;
  logic [AW-1:0] rx_rd_ptr;
  logic [AW:0]   rx_count;

  logic          req;
  logic [1:0]    sel;
  logic          wr_acc;
  logic          rd_acc;
  logic          tx_empty;
  logic          tx_full;
  logic          rx_empty;
  logic          rx_full;
  logic          tx_push;
  logic          tx_pop;
  logic          rx_push;
  logic          rx_pop;
  logic          tx_ovf_set;
  logic          rx_unf_set;
  logic          ctl_wr;
  logic          tx_flush;
  logic          rx_flush;
  logic          flag_clr;
  logic [15:0]   status_word;
  logic [DW-1:0] rd_data;
  logic          unused_adr;

  assign unused_adr = ^{adr_i[15:3], adr_i[0]};

  assign req    = cyc_i & stb_i & ~ack_q;
  assign sel    = adr_i[2:1];
  assign wr_acc = req & we_i;
  assign rd_acc = req & ~we_i;

  // Full/empty come from registered counts, so same-edge pops never make room for a push.
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);

  assign tx_push    = wr_acc & (sel == REG_TXDATA) & ~tx_full;
  assign tx_ovf_set = wr_acc & (sel == REG_TXDATA) & tx_full;
  assign tx_pop     = ~tx_empty & tx_ready_i;

  assign rx_push    = rx_valid_i & ~rx_full;
  assign rx_pop     = rd_acc & (sel == REG_RXDATA) & ~rx_empty;
  assign rx_unf_set = rd_acc & (sel == REG_RXDATA) & rx_empty;

  assign ctl_wr   = wr_acc & (sel == REG_CONTROL);
  assign tx_flush = ctl_wr & dat_i[0];
  assign rx_flush = ctl_wr & dat_i[1];
  assign flag_clr = ctl_wr & dat_i[2];

  assign status_word = {4'(tx_count), 4'(rx_count), 2'b00, rx_unf, tx_ovf,
                        rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    rd_data = '0;
    if (!we_i) begin
      case (sel)
        REG_RXDATA: if (!rx_empty) rd_data = rx_mem[rx_rd_ptr];
        REG_STATUS: rd_data = DW'(status_word);
        default:    rd_data = '0;
      endcase
    end
  end

  // Storage arrays carry no reset; the pointers and counts define what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && tx_push) tx_mem[tx_wr_ptr] <= dat_i;
    if (!rst_i && rx_push) rx_mem[rx_wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) dat_q <= rd_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (AW+1)'(1);
        2'b01:   tx_count <= tx_count - (AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (AW+1)'(1);
        2'b01:   rx_count <= rx_count - (AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky error flags; a set and a clear cannot share an edge since they need different registers.
  always_ff @(posedge clk_i) begin
    if (rst_i || flag_clr) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_ovf_set) tx_ovf <= 1'b1;
      if (rx_unf_set) rx_unf <= 1'b1;
    end
  end

  assign ack_o      = ack_q;
  assign dat_o      = dat_q;
  assign tx_data_o  = tx_mem[tx_rd_ptr];
  assign tx_valid_o = ~tx_empty;
  assign rx_ready_o = ~rx_full;
  assign irq_o      = ~rx_empty;

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Bench for wb_fifo_slave: directed register-map scenarios followed by randomized traffic,
// all checked each cycle against a queue-based reference model.
module tb_wb_fifo_slave;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [15:0]   adr_i;
  logic [DW-1:0] dat_i;
  logic [DW-1:0] dat_o;
  logic          we_i;
  logic          cyc_i;
  logic          stb_i;
  logic          ack_o;
  logic [DW-1:0] tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic [DW-1:0] rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic          irq_o;

  always #5 clk_i = ~clk_i;

  wb_fifo_slave #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .dat_o      (dat_o),
    .we_i       (we_i),
    .cyc_i      (cyc_i),
    .stb_i      (stb_i),
    .ack_o      (ack_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .irq_o      (irq_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as queues, plus the bus-visible registers.
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  bit            m_ack;
  logic [DW-1:0] m_dat;
  bit            m_tx_ovf;
  bit            m_rx_unf;

  logic [DW-1:0] r;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge worth of rules to the model, using the inputs as currently driven.
  task automatic model_edge();
    int            tn;
    int            rn;
    bit            req;
    logic [15:0]   st;
    logic [DW-1:0] rd;
    if (rst_i) begin
      tx_q.delete();
      rx_q.delete();
      m_ack    = 0;
      m_dat    = '0;
      m_tx_ovf = 0;
      m_rx_unf = 0;
      return;
    end
    tn  = tx_q.size();
    rn  = rx_q.size();
    req = cyc_i && stb_i && !m_ack;
    st  = {4'(tn), 4'(rn), 2'b00, m_rx_unf, m_tx_ovf,
           rn == DEPTH, rn == 0, tn == DEPTH, tn == 0};
    rd  = '0;
    if (tx_ready_i && tn > 0) void'(tx_q.pop_front());
    if (rx_valid_i && rn < DEPTH) rx_q.push_back(rx_data_i);
    if (req) begin
      case (adr_i[2:1])
        2'd0: if (we_i) begin
          if (tn < DEPTH) tx_q.push_back(dat_i);
          else m_tx_ovf = 1;
        end
        2'd1: if (!we_i) begin
          if (rn > 0) rd = rx_q.pop_front();
          else m_rx_unf = 1;
        end
        2'd2: if (!we_i) rd = st;
        default: if (we_i) begin
          if (dat_i[0]) tx_q.delete();
          if (dat_i[1]) rx_q.delete();
          if (dat_i[2]) begin
            m_tx_ovf = 0;
            m_rx_unf = 0;
          end
        end
      endcase
      m_dat = rd;
    end
    m_ack = req;
  endtask

  task automatic check_outputs();
    check("ack_o", ack_o, m_ack);
    check("dat_o", dat_o, m_dat);
    check("tx_valid_o", tx_valid_o, tx_q.size() > 0);
    if (tx_q.size() > 0) check("tx_data_o", tx_data_o, tx_q[0]);
    check("rx_ready_o", rx_ready_o, rx_q.size() < DEPTH);
    check("irq_o", irq_o, rx_q.size() > 0);
  endtask

  // Inputs change at the falling edge; outputs are checked at the falling edge after each rising edge.
  task automatic step();
    model_edge();
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic bus(input bit w, input logic [1:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] rdata);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = w;
    adr_i = {13'b0, a, 1'b0};
    dat_i = d;
    step();
    check("ack_on", ack_o, 1'b1);
    rdata = dat_o;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    step();
    check("ack_off", ack_o, 1'b0);
  endtask

  initial begin
    rst_i      = 1'b1;
    adr_i      = '0;
    dat_i      = '0;
    we_i       = 1'b0;
    cyc_i      = 1'b0;
    stb_i      = 1'b0;
    tx_ready_i = 1'b0;
    rx_data_i  = '0;
    rx_valid_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    check("rst_ack", ack_o, 1'b0);
    check("rst_dat", dat_o, 16'h0000);
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_rx_ready", rx_ready_o, 1'b1);
    check("rst_irq", irq_o, 1'b0);

    bus(1'b0, 2'd2, '0, r);
    check("status_reset", r, 16'h0005);

    // Held strobe: acks separated by a low cycle
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 16'h0004;
    step(); check("hold_ack0", ack_o, 1'b1);
    step(); check("hold_ack1", ack_o, 1'b0);
    step(); check("hold_ack2", ack_o, 1'b1);
    cyc_i = 1'b0; stb_i = 1'b0;
    step();

    // Fill TX past full with the consumer stalled
    tx_ready_i = 1'b0;
    for (int i = 1; i <= 9; i++) bus(1'b1, 2'd0, 16'(i), r);
    bus(1'b0, 2'd2, '0, r);
    check("status_tx_full", r, 16'h8016);
    tx_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", tx_valid_o, 1'b1);
      check("drain_data", tx_data_o, 16'(i));
      step();
    end
    check("drain_done", tx_valid_o, 1'b0);
    tx_ready_i = 1'b0;
    bus(1'b1, 2'd3, 16'h0004, r);

    // RX stream then CPU reads, ending in underflow
    rx_valid_i = 1'b1; rx_data_i = 16'hA5A5;
    step();
    check("irq_first", irq_o, 1'b1);
    rx_data_i = 16'h5A5A;
    step();
    rx_valid_i = 1'b0;
    bus(1'b0, 2'd1, '0, r);
    check("rx_rd0", r, 16'hA5A5);
    check("irq_mid", irq_o, 1'b1);
    bus(1'b0, 2'd1, '0, r);
    check("rx_rd1", r, 16'h5A5A);
    check("irq_clear", irq_o, 1'b0);
    bus(1'b0, 2'd1, '0, r);
    check("rx_rd_empty", r, 16'h0000);
    bus(1'b0, 2'd2, '0, r);
    check("status_unf", r, 16'h0025);
    bus(1'b1, 2'd3, 16'h0004, r);

    // CPU push to full TX on the same edge as a stream pop
    for (int i = 0; i < 8; i++) bus(1'b1, 2'd0, 16'h0100 + 16'(i), r);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0000; dat_i = 16'hBEEF;
    tx_ready_i = 1'b1;
    step();
    check("ovf_ack", ack_o, 1'b1);
    tx_ready_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    step();
    bus(1'b0, 2'd2, '0, r);
    check("status_ovf", r, 16'h7014);
    check("tx_head_after", tx_data_o, 16'h0101);
    bus(1'b1, 2'd3, 16'h0005, r);
    check("tx_flushed", tx_valid_o, 1'b0);

    // Fill RX, then flush with the producer still offering data
    bus(1'b0, 2'd1, '0, r);
    rx_valid_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data_i = 16'h0200 + 16'(i);
      step();
    end
    rx_data_i = 16'hDEAD;
    check("rx_full_ready", rx_ready_o, 1'b0);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0006; dat_i = 16'h0007;
    step();
    check("flush_rx_ready", rx_ready_o, 1'b1);
    check("flush_irq", irq_o, 1'b0);
    rx_valid_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    step();
    bus(1'b0, 2'd2, '0, r);
    check("status_flushed", r, 16'h0005);

    // Strobe without cycle
    stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0000; dat_i = 16'h4321;
    step();
    check("stb_only_ack", ack_o, 1'b0);
    stb_i = 1'b0; we_i = 1'b0;
    step();
    check("stb_only_tx", tx_valid_o, 1'b0);

    // Reset landing on the request edge of a TXDATA write
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0000; dat_i = 16'h1234;
    rst_i = 1'b1;
    step();
    check("rst_mid_ack", ack_o, 1'b0);
    check("rst_mid_tx", tx_valid_o, 1'b0);
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    step();
    check("rst_mid_ack2", ack_o, 1'b0);
    check("rst_mid_tx2", tx_valid_o, 1'b0);
    bus(1'b0, 2'd2, '0, r);
    check("status_after_rst", r, 16'h0005);

    // Randomized traffic on both streams and the bus
    for (int i = 0; i < 600; i++) begin
      rst_i = (i == 300);
      if (m_ack) begin
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      end else if (!cyc_i) begin
        stb_i = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          cyc_i = 1'b1;
          stb_i = 1'b1;
          we_i  = 1'($urandom_range(0, 1));
          adr_i = 16'($urandom);
          adr_i[2:1] = 2'($urandom_range(0, 3));
          dat_i = 16'($urandom);
          if (adr_i[2:1] == 2'd3 && $urandom_range(0, 3) != 0) dat_i[1:0] = 2'b00;
        end else if ($urandom_range(0, 9) == 0) begin
          stb_i = 1'b1;
          we_i  = 1'b1;
          adr_i = 16'h0000;
          dat_i = 16'($urandom);
        end
      end
      tx_ready_i = ($urandom_range(0, 3) == 0);
      rx_valid_i = 1'($urandom_range(0, 1));
      rx_data_i  = 16'($urandom);
      step();
    end
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    rx_valid_i = 1'b0; tx_ready_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
